// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all stimulus vectors, samples a combinational DUT and tallies truth-table mismatches
module truth_table_checker #(
  parameter int N_IN = 4,
  parameter int DWELL = 4,
  parameter logic [2**N_IN-1:0] EXPECTED = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail,
  output logic            first_fail_vld
);
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  state_t state, state_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [N_IN-1:0] stim_n, first_fail_n;
  logic [N_IN:0] err_n;
  logic ffv_n, last, miss, go;
  assign last = dcnt == DW'(DWELL - 1);
  // X/Z on dut_out counts as a mismatch in simulation
  assign miss = dut_out !== EXPECTED[stim];
  assign go = start && state != APPLY;
  assign busy = state == APPLY;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  always_comb begin
    state_n = state;
    stim_n = stim;
    dcnt_n = dcnt;
    err_n = err_count;
    first_fail_n = first_fail;
    ffv_n = first_fail_vld;
    if (go) begin
      state_n = APPLY;
      stim_n = '0;
      dcnt_n = '0;
      err_n = '0;
      ffv_n = 1'b0;
    end else if (state == APPLY) begin
      dcnt_n = last ? '0 : dcnt + 1'b1;
      if (last) begin
        if (miss) begin
          err_n = err_count + 1'b1;
          first_fail_n = first_fail_vld ? first_fail : stim;
          ffv_n = 1'b1;
        end
        if (&stim) state_n = DONE;
        else stim_n = stim + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      stim <= '0;
      dcnt <= '0;
      err_count <= '0;
      first_fail <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      state <= state_n;
      stim <= stim_n;
      dcnt <= dcnt_n;
      err_count <= err_n;
      first_fail <= first_fail_n;
      first_fail_vld <= ffv_n;
    end
  end
endmodule

// File: tb/tb_truth_table_checker.sv
// tb_truth_table_checker: three checker configurations driven by bench-side truth-table DUT models
module tb_truth_table_checker;
  localparam logic [15:0] EA = 16'h0007, EB = 16'h8000, EC = 16'h00B4;
  logic clk = 0, rst = 1, start = 0;
  int sel = 0, checks = 0, errors = 0;
  logic [3:0] tt_a = '0;
  logic [15:0] tt_b = '0;
  logic [7:0] tt_c = '0;
  logic [1:0] stim_a; logic [3:0] stim_b; logic [2:0] stim_c;
  logic [2:0] err_a; logic [4:0] err_b; logic [3:0] err_c;
  logic [1:0] ff_a; logic [3:0] ff_b; logic [2:0] ff_c;
  logic busy_a, done_a, pass_a, ffv_a, busy_b, done_b, pass_b, ffv_b, busy_c, done_c, pass_c, ffv_c;
  logic [31:0] o_stim, o_err, o_ff;
  logic o_busy, o_done, o_pass, o_ffv;

  always #5 clk = ~clk;

  truth_table_checker #(.N_IN(2), .DWELL(4), .EXPECTED(EA[3:0])) u_a (
    .clk(clk), .rst(rst), .start(start && sel == 0), .dut_out(tt_a[stim_a]), .stim(stim_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail(ff_a), .first_fail_vld(ffv_a));
  truth_table_checker #(.N_IN(4), .DWELL(4), .EXPECTED(EB)) u_b (
    .clk(clk), .rst(rst), .start(start && sel == 1), .dut_out(tt_b[stim_b]), .stim(stim_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail(ff_b), .first_fail_vld(ffv_b));
  truth_table_checker #(.N_IN(3), .DWELL(1), .EXPECTED(EC[7:0])) u_c (
    .clk(clk), .rst(rst), .start(start && sel == 2), .dut_out(tt_c[stim_c]), .stim(stim_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c), .first_fail(ff_c), .first_fail_vld(ffv_c));

  always_comb begin
    o_stim = sel == 0 ? 32'(stim_a) : sel == 1 ? 32'(stim_b) : 32'(stim_c);
    o_err  = sel == 0 ? 32'(err_a)  : sel == 1 ? 32'(err_b)  : 32'(err_c);
    o_ff   = sel == 0 ? 32'(ff_a)   : sel == 1 ? 32'(ff_b)   : 32'(ff_c);
    o_busy = sel == 0 ? busy_a : sel == 1 ? busy_b : busy_c;
    o_done = sel == 0 ? done_a : sel == 1 ? done_b : done_c;
    o_pass = sel == 0 ? pass_a : sel == 1 ? pass_b : pass_c;
    o_ffv  = sel == 0 ? ffv_a  : sel == 1 ? ffv_b  : ffv_c;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference: mismatch count is the popcount of (observed xor expected), first fail is its lowest set bit
  task automatic model(input logic [15:0] d, input int n, output int e, output int f);
    e = 0;
    f = 0;
    for (int i = n - 1; i >= 0; i--) if (d[i]) begin e++; f = i; end
  endtask

  function automatic int sweep_len(input int s);
    return s == 0 ? 16 : s == 1 ? 64 : 8;
  endfunction

  task automatic sweep(input int s, input logic [15:0] tt, input string nm, input int inject,
                       input int exp_e, input int exp_f);
    int cyc;
    sel = s;
    tt_a = tt[3:0];
    tt_b = tt;
    tt_c = tt[7:0];
    start = 1;
    tick();
    start = 0;
    chk({nm, "_stim0"}, o_stim, 0);
    chk({nm, "_busy"}, 32'(o_busy), 1);
    chk({nm, "_err0"}, o_err, 0);
    cyc = 0;
    while (!o_done && cyc < 400) begin
      start = cyc == inject;
      tick();
      start = 0;
      cyc++;
    end
    chk({nm, "_lat"}, cyc, sweep_len(s));
    chk({nm, "_err"}, o_err, exp_e);
    chk({nm, "_pass"}, 32'(o_pass), 32'(exp_e == 0));
    chk({nm, "_ffv"}, 32'(o_ffv), 32'(exp_e != 0));
    if (exp_e != 0) chk({nm, "_ff"}, o_ff, exp_f);
    chk({nm, "_busy_end"}, 32'(o_busy), 0);
  endtask

  typedef struct {logic [3:0] tt; int err; int ff;} vec_t;
  vec_t tbl[6];

  initial begin
    int e, f, cyc;
    logic [15:0] r;
    tbl[0] = '{4'b0111, 0, 0};
    tbl[1] = '{4'b0000, 3, 0};
    tbl[2] = '{4'b1111, 1, 3};
    tbl[3] = '{4'b0110, 1, 0};
    tbl[4] = '{4'b0011, 1, 2};
    tbl[5] = '{4'b1000, 4, 0};
    tick();
    tick();
    rst = 0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #0;
      chk("rst_stim", o_stim, 0);
      chk("rst_flags", {o_busy, o_done, o_pass, o_ffv}, 0);
      chk("rst_err", o_err, 0);
      chk("rst_ff", o_ff, 0);
    end
    for (int i = 0; i < 6; i++) sweep(0, {12'h0, tbl[i].tt}, $sformatf("tbl%0d", i), -1, tbl[i].err, tbl[i].ff);
    sweep(1, 16'h7FFF, "inv_and4", -1, 16, 0);
    sweep(1, 16'h8000, "restart_ignored", 5, 0, 0);
    sel = 1;
    tt_b = 16'h7FFF;
    start = 1;
    tick();
    start = 0;
    cyc = 0;
    while (stim_b != 7 && cyc < 200) begin tick(); cyc++; end
    chk("reach_vec7", 32'(stim_b), 7);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_stim", o_stim, 0);
    chk("midrst_flags", {o_busy, o_done, o_pass, o_ffv}, 0);
    chk("midrst_err", o_err, 0);
    chk("midrst_ff", o_ff, 0);
    tick();
    chk("midrst_idle", 32'(o_busy), 0);
    sweep(1, 16'h8000, "after_rst", -1, 0, 0);
    sweep(2, 16'h00FF, "dw1_first", -1, 4, 0);
    start = 1;
    tick();
    start = 0;
    chk("dw1_done_drop", 32'(o_done), 0);
    chk("dw1_err_clr", o_err, 0);
    chk("dw1_s0", o_stim, 0);
    for (int k = 1; k < 3; k++) begin tick(); chk($sformatf("dw1_s%0d", k), o_stim, k); end
    cyc = 2;
    while (!o_done && cyc < 100) begin tick(); cyc++; end
    chk("dw1_lat", cyc, 8);
    for (int i = 0; i < 6; i++) begin
      r = 16'($urandom);
      if (i == 0) r = EB;
      model(r ^ EB, 16, e, f);
      sweep(1, r, $sformatf("rnd_b%0d", i), -1, e, f);
      r = 16'($urandom_range(0, 255));
      model((r ^ EC) & 16'h00FF, 8, e, f);
      sweep(2, r, $sformatf("rnd_c%0d", i), -1, e, f);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
